// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the 16-bit CPU front end.
//               Word/opcode geometry, the default HALT opcode and the fetch
//               state encoding used by fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    // Extract the major opcode field of an instruction word.
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the fetch stage's instruction-memory port, redirect
//               input, decode-side valid/ready output and status.
//               master : fetch unit side.  slave : memory/decode/control side.
//               With FETCH_PERF_EN defined, perf_fetch/perf_stall are added.
// Ports       : imem_addr, imem_data, redirect_vld, redirect_pc, out_valid,
//               out_ready, out_ins, out_pc, halted [, perf_fetch, perf_stall]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    import cpu_pkg::*;

    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_data;
    logic              redirect_vld;
    logic [WORD_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_ins;
    logic [WORD_W-1:0] out_pc;
    logic              halted;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetch;
    logic [31:0]       perf_stall;
`endif

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_vld,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_ins,
        output out_pc,
`ifdef FETCH_PERF_EN
        output perf_fetch,
        output perf_stall,
`endif
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_vld,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_ins,
        input  out_pc,
`ifdef FETCH_PERF_EN
        input  perf_fetch,
        input  perf_stall,
`endif
        input  halted
    );

endinterface

`default_nettype wire

// File: rtl/fetch_out_reg.sv
// ============================================================================
// Module      : fetch_out_reg
// Description : Single-entry valid/ready output register for the fetch stage.
//               flush has priority and drops the held word; load captures a
//               new {ins, pc}; accept without load empties the register.
// Ports       : clk, rst_n, flush, load, accept, in_ins, in_pc,
//               valid, ins, pc
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_out_reg
    import cpu_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush,
    input  wire logic              load,
    input  wire logic              accept,
    input  wire logic [WORD_W-1:0] in_ins,
    input  wire logic [WORD_W-1:0] in_pc,
    output logic                   valid,
    output logic [WORD_W-1:0]      ins,
    output logic [WORD_W-1:0]      pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ins   <= '0;
            pc    <= '0;
        end else if (flush) begin
            // Data fields are left untouched; valid=0 makes them don't-care.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            ins   <= in_ins;
            pc    <= in_pc;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, drives imem_addr,
//               registers the returned word with its PC and presents it to
//               decode over valid/ready. Supports branch redirect and HALT.
//               Optional macro FETCH_PERF_EN adds saturating perf counters
//               perf_fetch (loads) and perf_stall (valid & !ready cycles).
// Ports       : clk, rst_n (async, active low), bus (fetch_unit_if.master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0]   RESET_PC    = 16'h0000,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    fetch_unit_if.master    bus
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [WORD_W-1:0] pc_q;
    logic              load_en;
    logic              load;

    assign bus.imem_addr = pc_q;
    assign bus.halted    = (state_q == ST_HALTED);

    // Single output register with no bubble: refill whenever it is empty or
    // being drained this cycle. A redirect suppresses the load so the word
    // from the old path is discarded.
    assign load_en = (state_q == ST_RUN) && (!bus.out_valid || bus.out_ready);
    assign load    = load_en && !bus.redirect_vld;

    always_comb begin
        state_d = state_q;
        if (bus.redirect_vld) begin
            state_d = ST_RUN;
        end else if (load && (opcode_of(bus.imem_data) == HALT_OPCODE)) begin
            state_d = ST_HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // The HALT word itself advances the PC, so a halted PC rests at halt+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (bus.redirect_vld) begin
            pc_q <= bus.redirect_pc;
        end else if (load) begin
            pc_q <= pc_q + 16'd1;
        end
    end

    fetch_out_reg u_out_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (bus.redirect_vld),
        .load   (load),
        .accept (bus.out_ready),
        .in_ins (bus.imem_data),
        .in_pc  (pc_q),
        .valid  (bus.out_valid),
        .ins    (bus.out_ins),
        .pc     (bus.out_pc)
    );

`ifdef FETCH_PERF_EN
    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.perf_fetch <= '0;
            bus.perf_stall <= '0;
        end else begin
            if (load && (bus.perf_fetch != 32'hFFFF_FFFF)) begin
                bus.perf_fetch <= bus.perf_fetch + 32'd1;
            end
            if (bus.out_valid && !bus.out_ready && (bus.perf_stall != 32'hFFFF_FFFF)) begin
                bus.perf_stall <= bus.perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
